car_sequencer: RTL and testbench

CAR_SEQUENCER -- requirements
Module: car_sequencer

---
 rtl/car_sequencer.sv | 143 ++++++++++++++
 tb/tb_car_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/car_sequencer.sv
// Command sequencer for the CAR register set: decodes one command at a time
// and drives the per-CAR strobes for one or two execute cycles.
module car_sequencer #(
    parameter int unsigned NCAR = 5
) (
    input  logic            clock,
    input  logic            clear_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [2:0]      cmd_sel,
    input  logic [2:0]      cmd_dst,
    output logic [NCAR-1:0] car_inc,
    output logic [NCAR-1:0] car_dec,
    output logic [NCAR-1:0] car_xbus_load_n,
    output logic [NCAR-1:0] car_xbus_assert_n,
    output logic [NCAR-1:0] car_addr_assert_n,
    output logic            done,
    output logic            cmd_err
);

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, ERR} state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_INC   = 4'd1,
        OP_DEC   = 4'd2,
        OP_ADDR  = 4'd3,
        OP_LOAD  = 4'd4,
        OP_STORE = 4'd5,
        OP_MOVE  = 4'd6,
        OP_PUSH  = 4'd7,
        OP_POP   = 4'd8
    } op_t;

    localparam int unsigned     SP_IDX = 2;
    localparam logic [NCAR-1:0] SP_HOT = NCAR'(1) << SP_IDX;
    localparam logic [3:0]      NCAR_W = 4'(NCAR);

    state_t          state_q, state_d;
    op_t             op_q;
    logic [2:0]      sel_q, dst_q;
    logic            illegal;
    logic [NCAR-1:0] sel_hot, dst_hot;

    always_comb begin
        illegal = 1'b0;
        if (cmd_op > 4'd8)
            illegal = 1'b1;
        else if (cmd_op >= 4'd1 && cmd_op <= 4'd6 && {1'b0, cmd_sel} >= NCAR_W)
            illegal = 1'b1;
        if (cmd_op == OP_MOVE && ({1'b0, cmd_dst} >= NCAR_W || cmd_sel == cmd_dst))
            illegal = 1'b1;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Only legal commands are latched; ERR never looks at op/sel/dst.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            op_q  <= OP_NOP;
            sel_q <= '0;
            dst_q <= '0;
        end else if (cmd_valid && cmd_ready && !illegal) begin
            op_q  <= op_t'(cmd_op);
            sel_q <= cmd_sel;
            dst_q <= cmd_dst;
        end
    end

    always_comb begin
        sel_hot = '0;
        dst_hot = '0;
        for (int unsigned i = 0; i < NCAR; i++) begin
            sel_hot[i] = (sel_q == 3'(i));
            dst_hot[i] = (dst_q == 3'(i));
        end
    end

    always_comb begin
        state_d           = state_q;
        cmd_ready         = 1'b0;
        done              = 1'b0;
        cmd_err           = 1'b0;
        car_inc           = '0;
        car_dec           = '0;
        car_xbus_load_n   = '1;
        car_xbus_assert_n = '1;
        car_addr_assert_n = '1;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = illegal ? ERR : EXEC1;
            end
            EXEC1: begin
                state_d = IDLE;
                done    = 1'b1;
                case (op_q)
                    OP_INC:   car_inc           = sel_hot;
                    OP_DEC:   car_dec           = sel_hot;
                    OP_ADDR:  car_addr_assert_n = ~sel_hot;
                    OP_LOAD:  car_xbus_load_n   = ~sel_hot;
                    OP_STORE: car_xbus_assert_n = ~sel_hot;
                    OP_MOVE: begin
                        car_xbus_assert_n = ~sel_hot;
                        car_xbus_load_n   = ~dst_hot;
                    end
                    OP_PUSH: begin
                        car_dec = SP_HOT;
                        done    = 1'b0;
                        state_d = EXEC2;
                    end
                    OP_POP: begin
                        car_addr_assert_n = ~SP_HOT;
                        done              = 1'b0;
                        state_d           = EXEC2;
                    end
                    default: ;
                endcase
            end
            EXEC2: begin
                state_d = IDLE;
                done    = 1'b1;
                if (op_q == OP_PUSH)
                    car_addr_assert_n = ~SP_HOT;
                else
                    car_inc = SP_HOT;
            end
            ERR: begin
                state_d = IDLE;
                cmd_err = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_car_sequencer.sv
// Randomized bench for car_sequencer: a per-command list of expected output
// cycles is built from the command rules and compared every clock.
module tb_car_sequencer;

    localparam int NCAR = 5;

    logic            clock = 1'b0;
    logic            clear_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [3:0]      cmd_op = '0;
    logic [2:0]      cmd_sel = '0;
    logic [2:0]      cmd_dst = '0;
    logic [NCAR-1:0] car_inc, car_dec, car_xbus_load_n, car_xbus_assert_n, car_addr_assert_n;
    logic            done, cmd_err;

    car_sequencer #(.NCAR(NCAR)) dut (
        .clock             (clock),
        .clear_n           (clear_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_sel           (cmd_sel),
        .cmd_dst           (cmd_dst),
        .car_inc           (car_inc),
        .car_dec           (car_dec),
        .car_xbus_load_n   (car_xbus_load_n),
        .car_xbus_assert_n (car_xbus_assert_n),
        .car_addr_assert_n (car_addr_assert_n),
        .done              (done),
        .cmd_err           (cmd_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NCAR-1:0] inc, dec, ld_n, xa_n, aa_n;
        logic            done, err, ready;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r       = '0;
        r.ld_n  = '1;
        r.xa_n  = '1;
        r.aa_n  = '1;
        r.ready = 1'b1;
        return r;
    endfunction

    function automatic exp_t busy_rec();
        exp_t r;
        r       = idle_rec();
        r.ready = 1'b0;
        return r;
    endfunction

    // Expected cycles following acceptance of one command.
    task automatic push_model(input int op, input int sel, input int dst);
        exp_t r, r2;
        bit   legal;
        logic [NCAR-1:0] sh, dh;
        r     = busy_rec();
        r2    = busy_rec();
        legal = (op <= 8);
        if (op >= 1 && op <= 6 && sel >= NCAR) legal = 0;
        if (op == 6 && (dst >= NCAR || sel == dst)) legal = 0;
        if (!legal) begin
            r.err = 1'b1;
            q.push_back(r);
            return;
        end
        sh     = NCAR'(1 << sel);
        dh     = NCAR'(1 << dst);
        r.done = 1'b1;
        case (op)
            1: r.inc  = sh;
            2: r.dec  = sh;
            3: r.aa_n = ~sh;
            4: r.ld_n = ~sh;
            5: r.xa_n = ~sh;
            6: begin r.xa_n = ~sh; r.ld_n = ~dh; end
            7: begin r.done = 1'b0; r.dec = 5'b00100; r2.aa_n = 5'b11011; r2.done = 1'b1; end
            8: begin r.done = 1'b0; r.aa_n = 5'b11011; r2.inc = 5'b00100; r2.done = 1'b1; end
            default: ;
        endcase
        q.push_back(r);
        if (op >= 7) q.push_back(r2);
    endtask

    // One clock: compare outputs against the model, then drive the next inputs.
    task automatic step(input bit issue, input int op, input int sel, input int dst);
        exp_t e;
        @(negedge clock);
        e = (q.size() != 0) ? q.pop_front() : idle_rec();
        check("car_inc", car_inc, e.inc);
        check("car_dec", car_dec, e.dec);
        check("xbus_load_n", car_xbus_load_n, e.ld_n);
        check("xbus_assert_n", car_xbus_assert_n, e.xa_n);
        check("addr_assert_n", car_addr_assert_n, e.aa_n);
        check("done", done, e.done);
        check("cmd_err", cmd_err, e.err);
        check("cmd_ready", cmd_ready, e.ready);
        check("addr_onehot", 32'($countones(~car_addr_assert_n) <= 1), 1);
        check("xbus_onehot", 32'($countones(~car_xbus_assert_n) <= 1), 1);
        check("inc_dec_excl", 32'(car_inc & car_dec), 0);
        if (e.ready && issue) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'(op);
            cmd_sel   = 3'(sel);
            cmd_dst   = 3'(dst);
            push_model(op, sel, dst);
        end else if (e.ready) begin
            cmd_valid = 1'b0;
        end else begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 4'($urandom);
            cmd_sel   = 3'($urandom);
            cmd_dst   = 3'($urandom);
        end
    endtask

    task automatic issue(input int op, input int sel, input int dst);
        while (q.size() != 0) step(0, 0, 0, 0);
        step(1, op, sel, dst);
    endtask

    // Reset asserted during EXEC1 of a two-cycle command.
    task automatic reset_mid(input int op);
        issue(op, 0, 0);
        step(0, 0, 0, 0);
        #1;
        cmd_valid = 1'b0;
        clear_n   = 1'b0;
        #1;
        check("rst_addr_n", car_addr_assert_n, 5'b11111);
        check("rst_inc", car_inc, 0);
        check("rst_dec", car_dec, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        @(posedge clock);
        #1;
        check("rst_hold_inc", car_inc, 0);
        check("rst_hold_addr_n", car_addr_assert_n, 5'b11111);
        check("rst_hold_done", done, 0);
        @(negedge clock);
        clear_n = 1'b1;
        q.delete();
    endtask

    initial begin
        int op, sel, dst;
        #2;
        check("reset_ready", cmd_ready, 1);
        check("reset_inc", car_inc, 0);
        check("reset_xa_n", car_xbus_assert_n, 5'b11111);
        check("reset_err", cmd_err, 0);
        @(negedge clock);
        clear_n = 1'b1;

        issue(1, 2, 0);
        issue(6, 0, 4);
        issue(7, 0, 0);
        issue(6, 3, 3);
        issue(12, 0, 0);
        issue(1, 6, 0);
        issue(0, 0, 0);
        issue(8, 7, 7);
        reset_mid(8);
        reset_mid(7);

        for (int i = 0; i < 500; i++) begin
            op  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            sel = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            dst = int'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) step(0, 0, 0, 0);
            issue(op, sel, dst);
        end
        while (q.size() != 0) step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
